// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the byte-lane mask helper used by the store merge.
package lsu_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [LANES-1:0] lane_mask(input size_e size, input logic [1:0] offset);
    logic [LANES-1:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << offset;
      SZ_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: little-endian load extract with sign/zero
// extension, and read-modify-write merge of sub-word store data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [31:0] w_shifted;
  logic [31:0] w_repl;
  logic [3:0]  w_mask;

  assign w_shifted = i_word >> {i_offset, 3'b000};
  assign w_mask    = lane_mask(i_size, i_offset);

  always_comb begin
    o_load_data = w_shifted;
    case (i_size)
      SZ_BYTE: o_load_data = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
      SZ_HALF: o_load_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  // Replicate store data across lanes so the mask alone picks the target bytes.
  always_comb begin
    w_repl = i_wdata;
    case (i_size)
      SZ_BYTE: w_repl = {4{i_wdata[7:0]}};
      SZ_HALF: w_repl = {2{i_wdata[15:0]}};
      default: ;
    endcase
    o_merged = i_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_mask[b]) o_merged[8*b +: 8] = w_repl[8*b +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for data_memory; one request in flight.
// MISALIGN_TRAP_EN: defined -> misaligned requests error out; undefined -> low address bits are forced to 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            r_state, w_next;
  logic              r_we, r_unsigned, r_resp_err;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_resp_rdata;

  logic              w_accept, w_err;
  size_e             w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_load_data, w_merged;

  assign w_size   = size_e'(req_size);
  assign w_accept = req_valid & req_ready;

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_size == SZ_HALF) && req_addr[0]) ||
                      ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_err      = (w_size == SZ_ILL) || w_misalign;
  assign w_addr     = req_addr;
`else
  assign w_err = (w_size == SZ_ILL);
  always_comb begin
    w_addr = req_addr;
    case (w_size)
      SZ_HALF: w_addr[0]   = 1'b0;
      SZ_WORD: w_addr[1:0] = 2'b00;
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                             w_next = RESP;
          else if (req_we && w_size == SZ_WORD)  w_next = WR;
          else                                   w_next = RD;
        end
      end
      RD:      w_next = CAP;
      CAP:     w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready  = 1'b1;
      RD:      mem_read   = 1'b1;
      WR:      mem_write  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // r_wdata holds raw store data until CAP, then the merged word for WR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= SZ_BYTE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_we         <= req_we;
      r_unsigned   <= req_unsigned;
      r_size       <= w_size;
      r_addr       <= w_addr;
      r_wdata      <= req_we ? req_wdata : '0;
      r_resp_rdata <= '0;
      r_resp_err   <= w_err;
    end else if (r_state == CAP) begin
      if (r_we) r_wdata      <= w_merged;
      else      r_resp_rdata <= w_load_data;
    end
  end

  lsu_lane_align u_align (
    .i_word      (mem_read_data),
    .i_offset    (r_addr[1:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  assign mem_address    = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_write_data = r_wdata;
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed request table against a
// 16-word memory model, plus reset-in-flight and busy-request sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, preload;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [31:0] mem [16];
  logic [31:0] last_addr;
  int n_rd = 0, n_wr = 0, n_resp = 0, n_both = 0, n_unal = 0;
  int checks = 0, failures = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          nrd;
    int          nwr;
    logic        chkmem;
    logic [31:0] exp_mem;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // data_memory model: read data appears the cycle after mem_read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[2]        <= 32'h80FF7F01;
      mem_read_data <= '0;
      last_addr     <= '0;
    end else begin
      if (mem_write) mem[mem_address[5:2]] <= mem_write_data;
      if (mem_read)  mem_read_data <= mem[mem_address[5:2]];
      if (mem_read || mem_write) last_addr <= mem_address;
    end
  end

  always @(posedge clk) begin
    if (mem_read)  n_rd++;
    if (mem_write) n_wr++;
    if (resp_valid) n_resp++;
    if (mem_read && mem_write) n_both++;
    if ((mem_read || mem_write) && mem_address[1:0] != 2'b00) n_unal++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int lat, input int nrd, input int nwr,
                              input logic chkmem, input logic [31:0] exp_mem,
                              input logic [31:0] maddr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    v.chkmem = chkmem; v.exp_mem = exp_mem; v.maddr = maddr;
    return v;
  endfunction

  task automatic do_req(input vec_t v, input int idx);
    int rd0, wr0, lat;
    @(negedge clk);
    chk($sformatf("v%0d_ready_before", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), 32'(resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d_nread", idx), 32'(n_rd - rd0), 32'(v.nrd));
    chk($sformatf("v%0d_nwrite", idx), 32'(n_wr - wr0), 32'(v.nwr));
    if (v.nrd + v.nwr > 0) chk($sformatf("v%0d_mem_address", idx), last_addr, v.maddr);
    @(posedge clk); #1;
    chk($sformatf("v%0d_resp_drop", idx), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d_ready_after", idx), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d_rdata_hold", idx), resp_rdata, v.exp_rdata);
    if (v.chkmem) chk($sformatf("v%0d_mem", idx), mem[v.maddr[5:2]], v.exp_mem);
  endtask

  initial begin
    int rd0, wr0, rs0;
    //              we size u  addr          wdata         rdata         err lat rd wr cm exp_mem       maddr
    vecs.push_back(mk(1, 2'd2, 0, 32'h4,        32'h12345678, 32'h0,        0, 2, 0, 1, 1, 32'h12345678, 32'h4));
    vecs.push_back(mk(0, 2'd2, 0, 32'h4,        32'h0,        32'h12345678, 0, 3, 1, 0, 0, 32'h0,        32'h4));
    vecs.push_back(mk(0, 2'd0, 0, 32'hA,        32'h0,        32'hFFFFFFFF, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd0, 1, 32'hA,        32'h0,        32'h000000FF, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd1, 0, 32'hA,        32'h0,        32'hFFFF80FF, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd1, 1, 32'hA,        32'h0,        32'h000080FF, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd0, 0, 32'h8,        32'h0,        32'h00000001, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd1, 1, 32'h8,        32'h0,        32'h00007F01, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd0, 0, 32'h9,        32'h0,        32'h0000007F, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd0, 0, 32'hB,        32'h0,        32'hFFFFFF80, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(1, 2'd2, 0, 32'h8,        32'hAABBCCDD, 32'h0,        0, 2, 0, 1, 1, 32'hAABBCCDD, 32'h8));
    vecs.push_back(mk(1, 2'd0, 0, 32'h9,        32'hFFFFFF11, 32'h0,        0, 4, 1, 1, 1, 32'hAABB11DD, 32'h8));
    vecs.push_back(mk(1, 2'd1, 0, 32'hA,        32'h99992233, 32'h0,        0, 4, 1, 1, 1, 32'h223311DD, 32'h8));
    vecs.push_back(mk(0, 2'd2, 0, 32'h8,        32'h0,        32'h223311DD, 0, 3, 1, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(0, 2'd3, 0, 32'h8,        32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h8));
    vecs.push_back(mk(1, 2'd3, 0, 32'h8,        32'h0,        32'h0,        1, 1, 0, 0, 1, 32'h223311DD, 32'h8));
    vecs.push_back(mk(1, 2'd0, 0, 32'hB,        32'h0000005A, 32'h0,        0, 4, 1, 1, 1, 32'h5A3311DD, 32'h8));
    vecs.push_back(mk(1, 2'd1, 0, 32'h2,        32'h1234BEEF, 32'h0,        0, 4, 1, 1, 1, 32'hBEEF0000, 32'h0));
    vecs.push_back(mk(1, 2'd2, 0, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 1, 32'hCAFEF00D, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0,        32'hCAFEF00D, 0, 3, 1, 0, 0, 32'h0,        32'hFFFFFFFC));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 2'd1, 0, 32'h5,        32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h4));
    vecs.push_back(mk(0, 2'd2, 0, 32'h6,        32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h4));
`else
    vecs.push_back(mk(0, 2'd1, 0, 32'h5,        32'h0,        32'h00005678, 0, 3, 1, 0, 0, 32'h0,        32'h4));
    vecs.push_back(mk(0, 2'd2, 0, 32'h6,        32'h0,        32'h12345678, 0, 3, 1, 0, 0, 32'h0,        32'h4));
`endif

    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_mem_address", mem_address, 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0; preload = 1'b0;

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], i);

    // Reset while a sub-word store sits in CAP: the write must never happen.
    @(negedge clk);
    wr0 = n_wr; rs0 = n_resp;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h5; req_wdata = 32'h000000EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mid_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_nwrite", 32'(n_wr - wr0), 32'd0);
    chk("rst_mid_nresp", 32'(n_resp - rs0), 32'd0);
    chk("rst_mid_mem", mem[1], 32'h12345678);

    // Requests presented while busy must be ignored.
    @(negedge clk);
    rd0 = n_rd; wr0 = n_wr; rs0 = n_resp;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'hDEADBEEF;
    chk("busy_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("busy_ready_low2", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("busy_resp_valid", 32'(resp_valid), 32'd1);
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_rdata", resp_rdata, 32'h12345678);
    chk("busy_nresp", 32'(n_resp - rs0), 32'd1);
    chk("busy_nread", 32'(n_rd - rd0), 32'd1);
    chk("busy_nwrite", 32'(n_wr - wr0), 32'd0);
    chk("busy_mem", mem[1], 32'h12345678);

    chk("rd_wr_overlap", 32'(n_both), 32'd0);
    chk("unaligned_mem_address", 32'(n_unal), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
